regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have the port: clk  input  1  system clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port: rst  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have the port: req0_valid  input  1  write request from pipeline WB stage.
REQ-004 The block SHALL have the port: req0_reg  input  5  destination register of requester 0.
REQ-005 The block SHALL have the port: req0_data  input  32  write data of requester 0.
REQ-006 The block SHALL have the port: req0_ready  output  1  requester 0 handshake accepted this cycle when req0_valid and req0_ready are both high.
REQ-007 The block SHALL have the ports req1_valid (input, 1), req1_reg (input, 5), req1_data (input, 32) and req1_ready (output, 1); these have the same meaning for requester 1, the multicycle unit.
REQ-008 The block SHALL have the port: rf_we  output  1  register-file write enable, registered.
REQ-009 The block SHALL have the port: rf_wreg  output  5  register-file write address, registered.
REQ-010 The block SHALL have the port: rf_wdata  output  32  register-file write data, registered.
REQ-011 The block SHALL have the port: pend_mask  output  32  bit k high while any buffered write to register k is not yet issued.

Function
REQ-012 Each requester SHALL own a one-entry holding buffer (valid, reg, data); a handshake loads it at the rising edge.
REQ-013 reqN_ready SHALL be high when bufN is empty or bufN is granted this cycle; it is combinational from buffer and grant state only, not from reqN_valid.
REQ-014 A handshake with reqN_reg = 0 SHALL be accepted and discarded: no buffer load, no rf_we, no pend_mask bit.
REQ-015 Each cycle at most one non-empty buffer SHALL be granted; the granted entry drives rf_we=1, rf_wreg and rf_wdata at the next rising edge and its buffer empties at the same edge.
REQ-016 When no buffer is granted, rf_we SHALL be 0 at the next edge; rf_wreg and rf_wdata hold their last values.
REQ-017 Minimum latency SHALL be handshake at edge N, buffer valid after N, rf_we high after edge N+1; with an uncontended buffer, one write issues per cycle per requester at full throughput.
REQ-018 Each buffer SHALL carry an age bit; when both buffers hold the same register, the earlier-loaded entry SHALL be granted first, overriding REQ-020/REQ-027.
REQ-019 When both buffers load the same register at the same edge, buf1 SHALL be granted first so that the requester-0 value is the final value.
REQ-020 When both buffers hold different registers (default build), buf0 SHALL be granted.
REQ-021 pend_mask SHALL be the OR of the one-hot decodes of valid buffer registers, derived combinationally from buffer state.
REQ-022 A buffer loaded while its previous entry drains in the same cycle SHALL hold the new entry after the edge, with no bubble and no loss.

Reset
REQ-023 While rst is low, both buffers SHALL be empty, age bits cleared and the round-robin pointer set to requester 0.
REQ-024 While rst is low, rf_we SHALL be 0, rf_wreg 0, rf_wdata 0, pend_mask 0, req0_ready 1 and req1_ready 1.
REQ-025 Reset asserted mid-operation SHALL discard buffered writes immediately, with no rf_we pulse during or after reset.
REQ-026 The first handshake SHALL occur at the first rising edge with rst high.

Configuration
REQ-027 With macro RFWA_ROUND_ROBIN_EN defined, grants between different registers SHALL alternate: the requester not granted last wins, and the pointer updates only on a grant.
REQ-028 Without RFWA_ROUND_ROBIN_EN, fixed priority per REQ-020 SHALL apply and no pointer state SHALL exist; REQ-018 and REQ-019 apply in both builds.

Verification
REQ-029 The bench SHALL cover: after reset, req0 writes r5=0xDEADBEEF at edge 1 -> rf_we=1, rf_wreg=5, rf_wdata=0xDEADBEEF after edge 2; pend_mask[5]=1 between edges 1 and 2.
REQ-030 The bench SHALL cover: req0 (r3=0x11) and req1 (r4=0x22) handshake at the same edge, default build -> r3 issues first, r4 next cycle; req1_ready=0 for one cycle if req1 is still valid.
REQ-031 The bench SHALL cover: same-edge req0 r7=0xAAAA and req1 r7=0xBBBB -> issue order 0xBBBB then 0xAAAA.
REQ-032 The bench SHALL cover: req1 loads r9=1, then req0 loads r9=2 one edge later while buf1 is still stalled -> 1 issues before 2.
REQ-033 The bench SHALL cover: req0 writes r0=0x5 -> no rf_we, pend_mask=0, req0_ready stays 1.
REQ-034 The bench SHALL cover: both buffers full, rst driven low between clock edges -> rf_we=0 and pend_mask=0 immediately, and no write after release; in the RFWA_ROUND_ROBIN_EN build, continuous contention yields an alternating 0,1,0,1 grant sequence.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter: two-requester register-file write arbiter with    |
// | one-entry holding buffers, same-register age ordering and pend_mask.     |
// | Optional build macro: RFWA_ROUND_ROBIN_EN (round-robin between regs).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wreg,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask
);

  logic        r_v0, r_v1;
  logic [4:0]  r_reg0, r_reg1;
  logic [31:0] r_data0, r_data1;
  logic        r_age0, r_age1;
`ifdef RFWA_ROUND_ROBIN_EN
  logic        r_ptr;
`endif

  logic w_gnt0, w_gnt1, w_ld0, w_ld1, w_nv0, w_nv1;

  // Same-register entries go oldest first; a tie (same-edge load) favours buf1.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_v0 && r_v1) begin
      if (r_reg0 == r_reg1) begin
        if (r_age0 && !r_age1) w_gnt0 = 1'b1;
        else                   w_gnt1 = 1'b1;
      end else begin
`ifdef RFWA_ROUND_ROBIN_EN
        w_gnt0 = !r_ptr;
        w_gnt1 = r_ptr;
`else
        w_gnt0 = 1'b1;
`endif
      end
    end else begin
      w_gnt0 = r_v0;
      w_gnt1 = r_v1;
    end
  end

  assign req0_ready = !r_v0 || w_gnt0;
  assign req1_ready = !r_v1 || w_gnt1;
  assign w_ld0      = req0_valid && req0_ready && (req0_reg != 5'd0);
  assign w_ld1      = req1_valid && req1_ready && (req1_reg != 5'd0);
  assign w_nv0      = w_ld0 || (r_v0 && !w_gnt0);
  assign w_nv1      = w_ld1 || (r_v1 && !w_gnt1);

  always_comb begin
    pend_mask = 32'd0;
    if (r_v0) pend_mask[r_reg0] = 1'b1;
    if (r_v1) pend_mask[r_reg1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_reg0   <= 5'd0;
      r_reg1   <= 5'd0;
      r_data0  <= 32'd0;
      r_data1  <= 32'd0;
      r_age0   <= 1'b0;
      r_age1   <= 1'b0;
`ifdef RFWA_ROUND_ROBIN_EN
      r_ptr    <= 1'b0;
`endif
      rf_we    <= 1'b0;
      rf_wreg  <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_we <= w_gnt0 || w_gnt1;
      if (w_gnt0) begin
        rf_wreg  <= r_reg0;
        rf_wdata <= r_data0;
      end else if (w_gnt1) begin
        rf_wreg  <= r_reg1;
        rf_wdata <= r_data1;
      end
`ifdef RFWA_ROUND_ROBIN_EN
      if (w_gnt0)      r_ptr <= 1'b1;
      else if (w_gnt1) r_ptr <= 1'b0;
`endif
      r_v0 <= w_nv0;
      r_v1 <= w_nv1;
      if (w_ld0) begin
        r_reg0  <= req0_reg;
        r_data0 <= req0_data;
      end
      if (w_ld1) begin
        r_reg1  <= req1_reg;
        r_data1 <= req1_data;
      end
      // A surviving entry is older than anything loaded alongside it.
      if (w_ld0 && w_ld1) begin
        r_age0 <= 1'b0;
        r_age1 <= 1'b1;
      end else if (w_ld0) begin
        r_age0 <= 1'b0;
        r_age1 <= w_nv1;
      end else if (w_ld1) begin
        r_age0 <= w_nv0;
        r_age1 <= 1'b0;
      end else begin
        r_age0 <= r_age0 && w_nv0;
        r_age1 <= r_age1 && w_nv1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus randomized
// traffic checked against a timestamp-based buffer model.
`default_nettype none

module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_reg = 5'd0, req1_reg = 5'd0;
  logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
  logic        req0_ready, req1_ready, rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata, pend_mask;

  int total = 0;
  int passed = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] r, input logic [31:0] d);
    req0_valid = v; req0_reg = r; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [4:0] r, input logic [31:0] d);
    req1_valid = v; req1_reg = r; req1_data = d;
  endtask

  task automatic do_reset();
    drive0(0, 0, 0);
    drive1(0, 0, 0);
    #3 rst = 1'b0;
    step();
    step();
    #3 rst = 1'b1;
    step();
  endtask

  // Reference model: buffer contents with load timestamps.
  logic        mv [2];
  logic [4:0]  mr [2];
  logic [31:0] md [2];
  int          mt [2];
  logic        mptr;
  logic        ew;
  logic [4:0]  ereg;
  logic [31:0] edata, epend;
  logic        er0, er1;
  int          g;

  initial begin
    // Reset state
    #2;
    chk("rst_we", rf_we, 0);
    chk("rst_wreg", rf_wreg, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_rdy0", req0_ready, 1);
    chk("rst_rdy1", req1_ready, 1);
    #10 rst = 1'b1;

    // Basic write r5 with minimum latency
    drive0(1, 5, 32'hDEADBEEF);
    step();
    drive0(0, 0, 0);
    chk("b_pend", pend_mask, 32'h20);
    chk("b_we0", rf_we, 0);
    step();
    chk("b_we", rf_we, 1);
    chk("b_wreg", rf_wreg, 5);
    chk("b_wdata", rf_wdata, 32'hDEADBEEF);
    chk("b_pend_clr", pend_mask, 0);
    step();
    chk("b_we_off", rf_we, 0);
    chk("b_hold", rf_wdata, 32'hDEADBEEF);

`ifndef RFWA_ROUND_ROBIN_EN
    // Contention between different registers: req0 wins
    drive0(1, 3, 32'h11);
    drive1(1, 4, 32'h22);
    step();
    drive0(0, 0, 0);
    drive1(1, 10, 32'h33);
    chk("c_pend", pend_mask, 32'h18);
    chk("c_rdy1", req1_ready, 0);
    step();
    chk("c_wreg1", rf_wreg, 3);
    chk("c_wdata1", rf_wdata, 32'h11);
    chk("c_rdy1b", req1_ready, 1);
    step();
    drive1(0, 0, 0);
    chk("c_wreg2", rf_wreg, 4);
    chk("c_wdata2", rf_wdata, 32'h22);
    chk("c_pend2", pend_mask, 32'h400);
    step();
    chk("c_wdata3", rf_wdata, 32'h33);
    step();
    chk("c_idle", rf_we, 0);
`endif

    // Same register at the same edge: requester 0 value lands last
    drive0(1, 7, 32'hAAAA);
    drive1(1, 7, 32'hBBBB);
    step();
    drive0(0, 0, 0);
    drive1(0, 0, 0);
    chk("s_pend", pend_mask, 32'h80);
    step();
    chk("s_first", rf_wdata, 32'hBBBB);
    step();
    chk("s_second", rf_wdata, 32'hAAAA);
    chk("s_wreg", rf_wreg, 7);
    step();
    chk("s_idle", rf_we, 0);

`ifndef RFWA_ROUND_ROBIN_EN
    // Older buf1 entry to r9 beats a newer buf0 entry to r9
    drive0(1, 2, 32'h20);
    drive1(1, 9, 32'h1);
    step();
    drive1(0, 0, 0);
    drive0(1, 9, 32'h2);
    chk("a_rdy0", req0_ready, 1);
    step();
    drive0(0, 0, 0);
    chk("a_wreg0", rf_wreg, 2);
    step();
    chk("a_first", rf_wdata, 32'h1);
    step();
    chk("a_second", rf_wdata, 32'h2);
    chk("a_wreg", rf_wreg, 9);
    step();
`endif

    // Write to r0 is discarded
    drive0(1, 0, 32'h5);
    step();
    drive0(0, 0, 0);
    chk("z_pend", pend_mask, 0);
    chk("z_rdy0", req0_ready, 1);
    step();
    chk("z_we", rf_we, 0);

    // Mid-operation reset with both buffers full and a write issuing
    drive0(1, 11, 32'h1111);
    step();
    drive0(1, 12, 32'h1212);
    drive1(1, 13, 32'h1313);
    step();
    drive0(0, 0, 0);
    drive1(0, 0, 0);
    chk("r_we_pre", rf_we, 1);
    chk("r_pend_pre", pend_mask, 32'h3000);
    #3 rst = 1'b0;
    #1;
    chk("r_we", rf_we, 0);
    chk("r_pend", pend_mask, 0);
    chk("r_rdy0", req0_ready, 1);
    chk("r_rdy1", req1_ready, 1);
    step();
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r_nowrite", rf_we, 0);
    end

`ifdef RFWA_ROUND_ROBIN_EN
    // Continuous contention alternates grants starting from requester 0
    do_reset();
    drive0(1, 20, 32'h20);
    drive1(1, 21, 32'h21);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_order", rf_wreg, (i % 2 == 0) ? 32'd20 : 32'd21);
    end
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 2; n++) begin
      mv[n] = 0; mr[n] = 0; md[n] = 0; mt[n] = 0;
    end
    mptr = 0; ew = 0; ereg = 0; edata = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      drive0(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      drive1(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      g = -1;
      if (mv[0] && mv[1]) begin
        if (mr[0] == mr[1]) g = (mt[0] < mt[1]) ? 0 : 1;
`ifdef RFWA_ROUND_ROBIN_EN
        else g = mptr ? 1 : 0;
`else
        else g = 0;
`endif
      end else if (mv[0]) g = 0;
      else if (mv[1]) g = 1;
      er0 = !mv[0] || (g == 0);
      er1 = !mv[1] || (g == 1);
      chk("rnd_rdy0", req0_ready, er0);
      chk("rnd_rdy1", req1_ready, er1);
      step();
      ew = (g >= 0);
      if (g >= 0) begin
        ereg  = mr[g];
        edata = md[g];
        mv[g] = 0;
        mptr  = (g == 0);
      end
      if (req0_valid && er0 && req0_reg != 0) begin
        mv[0] = 1; mr[0] = req0_reg; md[0] = req0_data; mt[0] = cyc;
      end
      if (req1_valid && er1 && req1_reg != 0) begin
        mv[1] = 1; mr[1] = req1_reg; md[1] = req1_data; mt[1] = cyc;
      end
      epend = 32'd0;
      for (int n = 0; n < 2; n++) if (mv[n]) epend[mr[n]] = 1'b1;
      chk("rnd_we", rf_we, ew);
      chk("rnd_wreg", rf_wreg, ereg);
      chk("rnd_wdata", rf_wdata, edata);
      chk("rnd_pend", pend_mask, epend);
    end
    drive0(0, 0, 0);
    drive1(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
